// File: rtl/nmi_pkg.sv
// Shared types and constants for the native memory initiator.
package nmi_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUS  = 2'd1,
        RESP = 2'd2
    } nmi_state_t;

    localparam logic [3:0] WSTRB_READ = 4'b0000;
    localparam logic [3:0] WSTRB_WORD = 4'b1111;

    localparam int NMI_TIMEOUT_DEFAULT = 256;

    function automatic logic nmi_is_write(input logic [3:0] wstrb);
        return wstrb != WSTRB_READ;
    endfunction

endpackage

// File: rtl/nmi_timeout_ctr.sv
// Bus-wait watchdog: loaded on command accept, counts down while the request
// is outstanding, and flags expiry on the last permitted wait cycle.
module nmi_timeout_ctr
    import nmi_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = NMI_TIMEOUT_DEFAULT
) (
    input  logic clk,
    input  logic rst,
    input  logic load,
    input  logic count,
    output logic expire
);

    localparam int CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

    logic [CW-1:0] cnt;

    always_ff @(posedge clk) begin
        if (!rst) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= CW'(TIMEOUT_CYCLES - 1);
        end else if (count && (cnt != '0)) begin
            cnt <= cnt - 1'b1;
        end
    end

    // Reaching zero means TIMEOUT_CYCLES-1 cycles have already gone unanswered.
    assign expire = (cnt == '0);

endmodule

// File: rtl/native_mem_initiator.sv
// Bus-master end of the PicoRV32 native memory interface: one command in, one
// native-bus transaction out, one response back. Optional bus-wait timeout
// is compiled in with NMI_TIMEOUT_EN.
//
// state | meaning
// IDLE  | waiting for a command, cmd_ready high
// BUS   | mem_valid high, request held until mem_ready (or timeout)
// RESP  | rsp_valid high, waiting for rsp_ready
module native_mem_initiator
    import nmi_pkg::*;
#(
    parameter int ADDR_W         = 32,
    parameter int TIMEOUT_CYCLES = NMI_TIMEOUT_DEFAULT
) (
    input  logic              clk,
    input  logic              rst,

    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [31:0]       cmd_wdata,
    input  logic [3:0]        cmd_wstrb,
    input  logic              cmd_instr,

    output logic              mem_valid,
    output logic              mem_instr,
    input  logic              mem_ready,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    output logic [3:0]        mem_wstrb,
    input  logic [31:0]       mem_rdata,

    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [31:0]       rsp_rdata,
    output logic              rsp_err,
    output logic [31:0]       txn_count
);

    localparam logic [1:0] ST_IDLE = IDLE;
    localparam logic [1:0] ST_BUS  = BUS;
    localparam logic [1:0] ST_RESP = RESP;

    logic [1:0] state;
    logic       cmd_accept;
    logic       bus_done;
    logic       timeout_hit;
    logic [1:0] unused_addr_lsb;

    assign cmd_ready       = (state == ST_IDLE);
    assign cmd_accept      = cmd_valid && cmd_ready;
    assign bus_done        = (state == ST_BUS) && mem_ready;
    assign unused_addr_lsb = cmd_addr[1:0];

`ifdef NMI_TIMEOUT_EN
    logic expire;

    nmi_timeout_ctr #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_timeout_ctr (
        .clk    (clk),
        .rst    (rst),
        .load   (cmd_accept),
        .count  (state == ST_BUS),
        .expire (expire)
    );

    // mem_ready on the expiry edge still wins.
    assign timeout_hit = (state == ST_BUS) && !mem_ready && expire;

    always_ff @(posedge clk) begin
        if (!rst) begin
            rsp_err <= 1'b0;
        end else if (bus_done) begin
            rsp_err <= 1'b0;
        end else if (timeout_hit) begin
            rsp_err <= 1'b1;
        end
    end
`else
    logic [31:0] unused_timeout_cycles;

    assign unused_timeout_cycles = 32'(TIMEOUT_CYCLES);
    assign timeout_hit           = 1'b0;
    assign rsp_err               = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (!rst) begin
            state     <= ST_IDLE;
            mem_valid <= 1'b0;
            mem_instr <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            mem_wstrb <= '0;
            rsp_valid <= 1'b0;
            rsp_rdata <= '0;
            txn_count <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (cmd_valid) begin
                        mem_addr  <= {cmd_addr[ADDR_W-1:2], 2'b00};
                        mem_wdata <= cmd_wdata;
                        mem_wstrb <= cmd_wstrb;
                        mem_instr <= cmd_instr;
                        mem_valid <= 1'b1;
                        state     <= ST_BUS;
                    end
                end
                ST_BUS: begin
                    if (mem_ready) begin
                        mem_valid <= 1'b0;
                        rsp_rdata <= nmi_is_write(mem_wstrb) ? 32'd0 : mem_rdata;
                        rsp_valid <= 1'b1;
                        txn_count <= txn_count + 32'd1;
                        state     <= ST_RESP;
                    end else if (timeout_hit) begin
                        mem_valid <= 1'b0;
                        rsp_rdata <= 32'd0;
                        rsp_valid <= 1'b1;
                        txn_count <= txn_count + 32'd1;
                        state     <= ST_RESP;
                    end
                end
                ST_RESP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        state     <= ST_IDLE;
                    end
                end
                default: begin
                    mem_valid <= 1'b0;
                    rsp_valid <= 1'b0;
                    state     <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_native_mem_initiator.sv
// Self-checking bench for native_mem_initiator: vector table plus request and
// response scoreboards against a wait-state responder and a reference memory.
`timescale 1ns/1ps
module tb_native_mem_initiator;
    import nmi_pkg::*;

    localparam int TO = 8;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic [31:0] cmd_addr = '0;
    logic [31:0] cmd_wdata = '0;
    logic [3:0]  cmd_wstrb = '0;
    logic        cmd_instr = 1'b0;
    logic        mem_valid, mem_instr;
    logic        mem_ready = 1'b0;
    logic [31:0] mem_addr, mem_wdata;
    logic [3:0]  mem_wstrb;
    logic [31:0] mem_rdata = '0;
    logic        rsp_valid;
    logic        rsp_ready = 1'b0;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic [31:0] txn_count;

    always #5 clk = ~clk;

    native_mem_initiator #(.ADDR_W(32), .TIMEOUT_CYCLES(TO)) dut (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_addr(cmd_addr),
        .cmd_wdata(cmd_wdata), .cmd_wstrb(cmd_wstrb), .cmd_instr(cmd_instr),
        .mem_valid(mem_valid), .mem_instr(mem_instr), .mem_ready(mem_ready),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb),
        .mem_rdata(mem_rdata),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
        .rsp_err(rsp_err), .txn_count(txn_count)
    );

    typedef struct {
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
        logic        instr;
        int          waits;
        int          bp;
        logic [31:0] exp_rdata;
    } vec_t;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
        logic        instr;
    } req_t;

    int checks = 0;
    int errors = 0;

    req_t        req_q[$];
    logic [32:0] rsp_q[$];
    logic [31:0] ref_mem[0:63];
    logic [31:0] bus_mem[0:63];

    int   cur_wait = 0;
    int   wcnt = 0;
    int   bp_cnt = 0;
    logic spurious = 1'b0;
    logic expect_rsp = 1'b0;
    logic mon_en = 1'b0;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] d,
                                          input logic [3:0] s);
        logic [31:0] r;
        r = old;
        for (int i = 0; i < 4; i++)
            if (s[i]) r[8*i +: 8] = d[8*i +: 8];
        return r;
    endfunction

    // Responder: asserts mem_ready after cur_wait wait cycles.
    always @(negedge clk) begin
        if (expect_rsp) begin
            chk("rsp_latency", {rsp_valid, mem_valid}, 2'b10);
            expect_rsp = 1'b0;
        end
        if (mem_valid && rst) begin
            if (wcnt >= cur_wait) begin
                mem_ready = 1'b1;
                mem_rdata = bus_mem[mem_addr[7:2]];
                bus_mem[mem_addr[7:2]] = merge(bus_mem[mem_addr[7:2]], mem_wdata, mem_wstrb);
                expect_rsp = 1'b1;
            end else begin
                mem_ready = 1'b0;
                mem_rdata = $urandom;
                wcnt++;
            end
        end else begin
            mem_ready = spurious;
            mem_rdata = 32'hBAD0_BAD0;
            wcnt = 0;
        end
    end

    // Monitors: request scoreboard, request stability, response scoreboard.
    logic        prev_mv = 1'b0;
    req_t        cur_req;
    logic        rsp_seen = 1'b0;
    logic [32:0] cur_rsp;
    always @(negedge clk) begin
        if (mon_en) begin
            chk("cmd_ready", cmd_ready, !(mem_valid || rsp_valid));
            if (mem_valid && !prev_mv) begin
                if (req_q.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL unexpected_req: got addr %0h expected no request", mem_addr);
                end else begin
                    cur_req = req_q.pop_front();
                    chk("mem_addr", mem_addr, cur_req.addr);
                    chk("mem_wdata", mem_wdata, cur_req.wdata);
                    chk("mem_wstrb", mem_wstrb, cur_req.wstrb);
                    chk("mem_instr", mem_instr, cur_req.instr);
                end
            end else if (mem_valid) begin
                chk("mem_stable", {mem_addr, mem_wdata, mem_wstrb, mem_instr},
                    {cur_req.addr, cur_req.wdata, cur_req.wstrb, cur_req.instr});
            end
            prev_mv = mem_valid;
            if (rsp_valid) begin
                if (!rsp_seen) begin
                    if (rsp_q.size() == 0) begin
                        checks++; errors++;
                        $display("FAIL unexpected_rsp: got %0h expected no response", rsp_rdata);
                        cur_rsp = {rsp_err, rsp_rdata};
                    end else begin
                        cur_rsp = rsp_q.pop_front();
                        chk("rsp_data", {rsp_err, rsp_rdata}, cur_rsp);
                    end
                    rsp_seen = 1'b1;
                end else begin
                    chk("rsp_hold", {rsp_err, rsp_rdata}, cur_rsp);
                end
                if (bp_cnt > 0) begin
                    rsp_ready = 1'b0;
                    bp_cnt--;
                end else begin
                    rsp_ready = 1'b1;
                end
            end else begin
                rsp_seen  = 1'b0;
                rsp_ready = 1'b0;
            end
        end
    end

    task automatic issue(input logic [31:0] addr, input logic [31:0] wdata,
                         input logic [3:0] wstrb, input logic instr, input int waits,
                         input int bp, input logic [32:0] exp_rsp);
        req_t r;
        int   budget;
        budget = 0;
        @(negedge clk);
        while (!cmd_ready && budget < 200) begin
            @(negedge clk);
            budget++;
        end
        if (!cmd_ready) begin
            checks++; errors++;
            $display("FAIL accept_timeout: got cmd_ready 0 expected 1");
            return;
        end
        cur_wait  = waits;
        bp_cnt    = bp;
        cmd_valid = 1'b1;
        cmd_addr  = addr;
        cmd_wdata = wdata;
        cmd_wstrb = wstrb;
        cmd_instr = instr;
        r.addr  = {addr[31:2], 2'b00};
        r.wdata = wdata;
        r.wstrb = wstrb;
        r.instr = instr;
        req_q.push_back(r);
        rsp_q.push_back(exp_rsp);
        @(posedge clk);
        #1 cmd_valid = 1'b0;
    endtask

    task automatic drain();
        int budget;
        budget = 0;
        while ((rsp_q.size() != 0 || !cmd_ready) && budget < 300) begin
            @(negedge clk);
            budget++;
        end
        checks++;
        if (rsp_q.size() != 0 || !cmd_ready) begin
            errors++;
            $display("FAIL drain_timeout: got %0d pending responses expected 0", rsp_q.size());
        end
    endtask

    vec_t vecs[9];

    initial begin
        int   hi;
        logic wr;
        logic [31:0] a, d;
        logic [3:0]  s;

        for (int i = 0; i < 64; i++) begin
            ref_mem[i] = '0;
            bus_mem[i] = '0;
        end

        vecs[0] = '{32'h10, 32'hDEAD_BEEF, 4'hF, 1'b0, 0, 0, 32'h0};
        vecs[1] = '{32'h10, 32'h0,         4'h0, 1'b0, 3, 0, 32'hDEAD_BEEF};
        vecs[2] = '{32'h23, 32'h1234_5678, 4'hF, 1'b0, 1, 0, 32'h0};
        vecs[3] = '{32'h23, 32'h0,         4'h0, 1'b0, 3, 5, 32'h1234_5678};
        vecs[4] = '{32'h30, 32'hAABB_CCDD, 4'hF, 1'b0, 0, 1, 32'h0};
        vecs[5] = '{32'h30, 32'h0000_1122, 4'h3, 1'b0, 2, 0, 32'h0};
        vecs[6] = '{32'h31, 32'h0,         4'h0, 1'b1, 0, 0, 32'hAABB_1122};
        vecs[7] = '{32'h44, 32'h5500_0000, 4'h8, 1'b0, 4, 2, 32'h0};
        vecs[8] = '{32'h46, 32'hFFFF_FFFF, 4'h0, 1'b1, 1, 0, 32'h5500_0000};

        repeat (3) @(posedge clk);
        #1;
        chk("rst_mem_valid", mem_valid, 1'b0);
        chk("rst_mem_fields", {mem_instr, mem_addr, mem_wdata, mem_wstrb}, '0);
        chk("rst_rsp", {rsp_valid, rsp_err, rsp_rdata}, '0);
        chk("rst_txn_count", txn_count, 32'd0);
        chk("rst_cmd_ready", cmd_ready, 1'b1);
        @(negedge clk);
        rst    = 1'b1;
        mon_en = 1'b1;

        // mem_ready while idle must be ignored
        spurious = 1'b1;
        repeat (4) @(negedge clk);
        chk("spurious_idle", {mem_valid, rsp_valid, txn_count}, '0);
        spurious = 1'b0;

        for (int i = 0; i < 9; i++) begin
            issue(vecs[i].addr, vecs[i].wdata, vecs[i].wstrb, vecs[i].instr,
                  vecs[i].waits, vecs[i].bp, {1'b0, vecs[i].exp_rdata});
            ref_mem[vecs[i].addr[7:2]] = merge(ref_mem[vecs[i].addr[7:2]],
                                               vecs[i].wdata, vecs[i].wstrb);
        end
        drain();
        chk("table_txn_count", txn_count, 32'd9);
        chk("mem_word4", bus_mem[4], 32'hDEAD_BEEF);

        // reset while the request is outstanding
        issue(32'h50, 32'h0, WSTRB_READ, 1'b0, 1000, 0, 33'h0);
        repeat (3) @(negedge clk);
        chk("pre_reset_valid", mem_valid, 1'b1);
        rst = 1'b0;
        @(posedge clk);
        #1;
        chk("reset_drop_valid", mem_valid, 1'b0);
        chk("reset_no_rsp", rsp_valid, 1'b0);
        chk("reset_txn_count", txn_count, 32'd0);
        rsp_q.delete();
        @(negedge clk);
        rst = 1'b1;
        repeat (4) @(negedge clk);
        chk("post_reset_no_rsp", rsp_valid, 1'b0);
        issue(32'h30, 32'h0, WSTRB_READ, 1'b0, 2, 0, {1'b0, ref_mem[12]});
        drain();
        chk("post_reset_txn_count", txn_count, 32'd1);

`ifdef NMI_TIMEOUT_EN
        issue(32'h40, 32'h0, WSTRB_READ, 1'b0, 1000, 1, 33'h1_0000_0000);
        hi = 0;
        for (int k = 0; k < 40; k++) begin
            if (!mem_valid) break;
            hi++;
            @(negedge clk);
        end
        chk("timeout_len", hi, TO);
        drain();
        chk("timeout_txn_count", txn_count, 32'd2);
`endif

        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;

        for (int i = 0; i < 16; i++) begin
            a  = 32'h80 + 32'($urandom_range(0, 15)) * 4 + 32'($urandom_range(0, 3));
            wr = 1'($urandom_range(0, 1));
            s  = wr ? 4'($urandom_range(1, 15)) : WSTRB_READ;
            d  = $urandom;
            issue(a, d, s, 1'($urandom_range(0, 1)), $urandom_range(0, 4),
                  $urandom_range(0, 2), {1'b0, wr ? 32'h0 : ref_mem[a[7:2]]});
            ref_mem[a[7:2]] = merge(ref_mem[a[7:2]], d, s);
        end
        drain();
        chk("random_txn_count", txn_count, 32'd16);
        chk("final_word4", bus_mem[4], ref_mem[4]);

        repeat (3) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got no finish expected finish before 500000ns");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/native_mem_initiator.md
Name: native_mem_initiator

Overview:
- Bus-master end of the PicoRV32 native memory interface (mem_valid/mem_ready/mem_addr/mem_wdata/mem_wstrb/mem_rdata).
- Accepts single read/write commands on a valid/ready command port and issues each one as one native-bus transaction.
- Holds the transaction until the responder asserts mem_ready, then returns read data or a write ack on a valid/ready response port.
- Used by bench loaders/checkers and DMA-style agents to drive the same memory model the CPU uses.

Parameters:
- ADDR_W, 32, native-bus address width.
- TIMEOUT_CYCLES, 256, max cycles mem_valid may wait for mem_ready; used only with NMI_TIMEOUT_EN.

Ports:
- clk  in  1  clock; all logic on rising edge.
- rst  in  1  reset, synchronous, active-low.
- cmd_valid  in  1  command present.
- cmd_ready  out  1  command accepted when cmd_valid & cmd_ready.
- cmd_addr  in  ADDR_W  byte address.
- cmd_wdata  in  32  write data.
- cmd_wstrb  in  4  byte strobes; 0 means read.
- cmd_instr  in  1  forwarded to mem_instr.
- mem_valid  out  1  native-bus request.
- mem_instr  out  1  instruction-fetch flag.
- mem_ready  in  1  responder completion.
- mem_addr  out  ADDR_W  word-aligned address.
- mem_wdata  out  32  write data.
- mem_wstrb  out  4  write strobes.
- mem_rdata  in  32  read data, valid when mem_ready.
- rsp_valid  out  1  response present.
- rsp_ready  in  1  response consumed.
- rsp_rdata  out  32  captured read data; 0 for writes.
- rsp_err  out  1  transaction timed out.
- txn_count  out  32  completed transactions; wraps at 2^32.

Behaviour:
- Reset (rst==0 at a clk edge): state IDLE; mem_valid, mem_instr, mem_addr, mem_wdata, mem_wstrb, rsp_valid, rsp_rdata, rsp_err, txn_count all 0. cmd_ready is combinational, =1 in IDLE, so it also reads 1 during reset.
- Reset mid-transaction: the request is dropped; mem_valid falls at that edge and no response is produced.
- FSM states: IDLE, BUS, RESP.
- IDLE:
  - cmd_ready=1.
  - On cmd_valid, register mem_addr={cmd_addr[ADDR_W-1:2],2'b00}, mem_wdata, mem_wstrb, mem_instr.
  - Set mem_valid=1 and go to BUS.
  - Request is visible one cycle after the accept edge.
- BUS:
  - cmd_ready=0.
  - mem_valid and all mem_* outputs are held stable.
  - On an edge where mem_ready=1:
    - mem_valid<=0.
    - rsp_rdata<=(mem_wstrb==0)?mem_rdata:0.
    - rsp_err<=0, rsp_valid<=1.
    - txn_count increments; go to RESP.
  - mem_ready in the same cycle mem_valid first rises completes immediately, so a combinational responder is supported.
- RESP:
  - rsp_valid held with rsp_rdata and rsp_err stable until rsp_valid&rsp_ready.
  - Then rsp_valid<=0 and go to IDLE.
  - No command is accepted while in RESP.
- Latency: accept at edge N; mem_valid high from N to N+1; with a zero-wait responder, rsp_valid is high after edge N+1.
- Throughput: at best one transaction every 3 cycles.
- mem_ready while mem_valid=0 is ignored.
- Unaligned cmd_addr: the low two bits are dropped; strobes are passed through unchanged (the caller positions bytes).
- cmd_wstrb with any bit set is a write; partial strobes such as 4'b0011 are legal.

Optional Feature:
- Macro NMI_TIMEOUT_EN.
- Defined:
  - A counter starts at 0 when BUS is entered and increments each cycle without mem_ready.
  - When it reaches TIMEOUT_CYCLES-1 with no mem_ready: mem_valid<=0, rsp_err<=1, rsp_rdata<=0, rsp_valid<=1; go to RESP.
  - txn_count still increments.
  - mem_ready arriving on that same edge wins, and the transaction completes normally.
- Undefined: BUS waits indefinitely and rsp_err is tied 0.

Decomposition:
- Package nmi_pkg holds:
  - state enum nmi_state_t {IDLE, BUS, RESP};
  - WSTRB_READ=4'b0000, WSTRB_WORD=4'b1111;
  - default TIMEOUT_CYCLES.
- One natural sub-module: nmi_timeout_ctr (load/count/expire), instantiated only under NMI_TIMEOUT_EN.

Test Plan:
- Write, zero-wait: addr 0x0000_0010, data 0xDEAD_BEEF, strb 4'hF, responder ready next cycle → mem_addr 0x10, mem_wstrb F; rsp_valid one cycle after mem_ready; rsp_rdata 0; memory word 4 = 0xDEADBEEF; txn_count=1.
- Read with 3 wait cycles: addr 0x13, responder returns 0x1234_5678 → mem_addr 0x10; mem_valid stays high 4 cycles with stable outputs; rsp_rdata 0x12345678; rsp_err 0.
- Response backpressure: rsp_ready low for 5 cycles → rsp_valid and rsp_rdata held; cmd_ready stays 0 until the handshake; next command accepted the cycle after.
- Reset mid-BUS: rst=0 while mem_valid=1 → mem_valid 0 after that edge; no rsp_valid; txn_count 0; after release a new read completes normally.
- NMI_TIMEOUT_EN, TIMEOUT_CYCLES=8, responder never ready → mem_valid high exactly 8 cycles; then rsp_valid with rsp_err=1, rsp_rdata 0.
- Back-to-back 16 mixed reads/writes, random waits 0–4 → read-after-write data matches; txn_count=16; mem_* outputs never change while mem_valid=1.
